pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program counter for the processor fetch path. It replaces the free-running increment-on-select counter with a clocked sequencer. The sequencer provides synchronous reset, stall, absolute jump, PC-relative branch, halt/resume, and an optional call/return stack. Its step requests come from memory control (load/add selects, combined into inc_en by the caller), and it drives the instruction address to memory.

Parameters:
PC_WIDTH, 8, width of pc and jump address in bits
INC_STEP, 1, unsigned increment applied on inc_en
RESET_VECTOR, 0, pc value loaded on reset
RAS_DEPTH, 4, return-address stack entries (used only with PC_RAS_EN)

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-high
stall  input  1  hold pc and all state this cycle
halt  input  1  request entry to HALT
resume  input  1  leave HALT
inc_en  input  1  sequential step request
jmp_en  input  1  absolute jump request
jmp_addr  input  PC_WIDTH  jump target
br_en  input  1  relative branch request
br_offset  input  PC_WIDTH  two's-complement branch offset
call_en  input  1  call: push return address, jump to jmp_addr (PC_RAS_EN only)
ret_en  input  1  return: pop stack into pc (PC_RAS_EN only)
pc  output  PC_WIDTH  current program counter (registered)
pc_valid  output  1  pc holds a fetchable address
halted  output  1  sequencer is in HALT
ras_overflow  output  1  sticky: push attempted while stack full
ras_underflow  output  1  sticky: pop attempted while stack empty

Behaviour:
- All state updates on rising clk. No combinational path from inputs to pc.
- Reset values: pc=RESET_VECTOR, pc_valid=0, halted=0, ras_overflow=0, ras_underflow=0, stack pointer=0, state=BOOT.
- reset dominates every other input, including mid-jump and mid-stall.
- FSM states: BOOT, RUN, HALT.
  - BOOT: pc_valid=0, pc held. Moves to RUN after exactly one cycle; stall is ignored in BOOT.
  - RUN: pc_valid=1. If halt=1 and stall=0, move to HALT; pc takes no update that cycle.
  - HALT: pc_valid=0, halted=1, pc held. If resume=1, move to RUN next cycle with pc unchanged. If halt and resume are both 1 in HALT, resume wins.
- RUN update priority (first true wins; only when stall=0): ret_en > call_en > jmp_en > br_en > inc_en > hold.
  - jmp: pc <= jmp_addr.
  - br: pc <= pc + br_offset, modulo 2^PC_WIDTH.
  - inc: pc <= pc + INC_STEP, modulo 2^PC_WIDTH.
  - Wrap-around: 2^PC_WIDTH-1 + 1 becomes 0; no flag is raised.
- stall=1 in RUN: pc, state, stack and flags all hold. Requests are dropped, not queued.
- Latency: a request sampled at edge N is visible on pc after edge N.
- Simultaneous requests: only the highest-priority request takes effect. Lower-priority requests are discarded silently.

Optional Feature:
Macro PC_RAS_EN.
- Defined: a RAS_DEPTH-entry LIFO is implemented.
  - call_en pushes pc+INC_STEP and loads jmp_addr.
  - ret_en pops the stack into pc.
  - Push when full: no push, jump still taken, ras_overflow set.
  - Pop when empty: pc follows inc rule instead, ras_underflow set.
  - Flags clear only on reset.
- Not defined: no stack storage. call_en behaves as jmp_en, ret_en is ignored, and both ras flags are tied to 0.

Test Plan:
- Reset with RESET_VECTOR=8'h10 -> pc=0x10, pc_valid=0 for one cycle then 1; three inc_en cycles -> 0x11, 0x12, 0x13.
- pc=0xFF, inc_en -> pc=0x00 with no flag; pc=0x05, br_en with br_offset=0xFE -> pc=0x03.
- jmp_en=1 and br_en=1 and inc_en=1 together, jmp_addr=0x40 -> pc=0x40; same request with stall=1 -> pc unchanged, request dropped.
- halt pulse at pc=0x22 -> halted=1, pc_valid=0, pc=0x22 for 5 cycles while inc_en=1; resume -> RUN, next inc gives 0x23.
- PC_RAS_EN, RAS_DEPTH=4: call to 0x80 from 0x10 -> pc=0x80; ret -> 0x11; five nested calls -> 5th jumps with ras_overflow=1; five returns -> 5th gives pc+1 with ras_underflow=1.
- Assert reset during a jmp_en cycle and during HALT -> pc=RESET_VECTOR, state BOOT, flags and stack cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer: BOOT/RUN/HALT control with stall, jump, relative branch and increment.
// Define PC_RAS_EN to add a RAS_DEPTH-entry call/return stack; without it call acts as jump and return is ignored.
module pc_sequencer #(
    parameter int                    PC_WIDTH     = 8,
    parameter int                    INC_STEP     = 1,
    parameter logic [PC_WIDTH-1:0]   RESET_VECTOR = '0,
    parameter int                    RAS_DEPTH    = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                halt,
    input  logic                resume,
    input  logic                inc_en,
    input  logic                jmp_en,
    input  logic [PC_WIDTH-1:0] jmp_addr,
    input  logic                br_en,
    input  logic [PC_WIDTH-1:0] br_offset,
    input  logic                call_en,
    input  logic                ret_en,
    output logic [PC_WIDTH-1:0] pc,
    output logic                pc_valid,
    output logic                halted,
    output logic                ras_overflow,
    output logic                ras_underflow
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] STEP = PC_WIDTH'(INC_STEP);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_pc_nxt;
    logic [PC_WIDTH-1:0] w_pc_inc;

    assign w_pc_inc = r_pc + STEP;

`ifdef PC_RAS_EN
    localparam int SP_W  = $clog2(RAS_DEPTH + 1);
    localparam int IDX_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_WIDTH-1:0] r_stack [RAS_DEPTH];
    logic [SP_W-1:0]     r_sp;
    logic                r_ras_ovf;
    logic                r_ras_unf;
    logic                w_push;
    logic                w_pop;
    logic                w_ovf_set;
    logic                w_unf_set;
    logic [IDX_W-1:0]    w_top_idx;
    logic [IDX_W-1:0]    w_push_idx;

    assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));
    assign w_push_idx = IDX_W'(r_sp);
`else
    logic w_unused;
    assign w_unused = ret_en;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
`ifdef PC_RAS_EN
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_ovf_set   = 1'b0;
        w_unf_set   = 1'b0;
`endif
        case (r_state)
            ST_BOOT: w_state_nxt = ST_RUN;
            ST_RUN: begin
                if (!stall) begin
                    if (halt) begin
                        w_state_nxt = ST_HALT;
`ifdef PC_RAS_EN
                    end else if (ret_en) begin
                        if (r_sp != '0) begin
                            w_pc_nxt = r_stack[w_top_idx];
                            w_pop    = 1'b1;
                        end else begin
                            w_pc_nxt  = w_pc_inc;
                            w_unf_set = 1'b1;
                        end
                    end else if (call_en) begin
                        w_pc_nxt = jmp_addr;
                        if (r_sp == SP_W'(RAS_DEPTH)) begin
                            w_ovf_set = 1'b1;
                        end else begin
                            w_push = 1'b1;
                        end
                    end else if (jmp_en) begin
`else
                    end else if (call_en || jmp_en) begin
`endif
                        w_pc_nxt = jmp_addr;
                    end else if (br_en) begin
                        w_pc_nxt = r_pc + br_offset;
                    end else if (inc_en) begin
                        w_pc_nxt = w_pc_inc;
                    end
                end
            end
            ST_HALT: begin
                if (resume && !stall) begin
                    w_state_nxt = ST_RUN;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VECTOR;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp      <= '0;
            r_ras_ovf <= 1'b0;
            r_ras_unf <= 1'b0;
        end else begin
            if (w_push) begin
                r_sp <= r_sp + SP_W'(1);
            end else if (w_pop) begin
                r_sp <= r_sp - SP_W'(1);
            end
            r_ras_ovf <= r_ras_ovf | w_ovf_set;
            r_ras_unf <= r_ras_unf | w_unf_set;
        end
    end

    // NOTE: stack entries are not reset; an empty stack is defined by r_sp alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign ras_overflow  = r_ras_ovf;
    assign ras_underflow = r_ras_unf;
`else
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    assign pc       = r_pc;
    assign pc_valid = (r_state == ST_RUN);
    assign halted   = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (PC_WIDTH=8, INC_STEP=1, RESET_VECTOR=8'h10, RAS_DEPTH=4).
// Stack checks follow PC_RAS_EN; without it, call/return fall back to jump/ignore behaviour.
module tb_pc_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       stall;
    logic       halt;
    logic       resume;
    logic       inc_en;
    logic       jmp_en;
    logic [7:0] jmp_addr;
    logic       br_en;
    logic [7:0] br_offset;
    logic       call_en;
    logic       ret_en;
    logic [7:0] pc;
    logic       pc_valid;
    logic       halted;
    logic       ras_overflow;
    logic       ras_underflow;

    int n_vec = 0;
    int n_err = 0;

    pc_sequencer #(
        .PC_WIDTH    (8),
        .INC_STEP    (1),
        .RESET_VECTOR(8'h10),
        .RAS_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .halt         (halt),
        .resume       (resume),
        .inc_en       (inc_en),
        .jmp_en       (jmp_en),
        .jmp_addr     (jmp_addr),
        .br_en        (br_en),
        .br_offset    (br_offset),
        .call_en      (call_en),
        .ret_en       (ret_en),
        .pc           (pc),
        .pc_valid     (pc_valid),
        .halted       (halted),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge, then settle away from it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall = 0; halt = 0; resume = 0; inc_en = 0; jmp_en = 0;
        br_en = 0; call_en = 0; ret_en = 0;
    endtask

    task automatic check_flags(input string tag, input logic exp_ovf, input logic exp_unf);
        check({tag, "_ovf"}, 32'(ras_overflow), 32'(exp_ovf));
        check({tag, "_unf"}, 32'(ras_underflow), 32'(exp_unf));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        reset = 1; jmp_addr = 8'h00; br_offset = 8'h00;
        step(); step();
        check("rst_pc", 32'(pc), 32'h10);
        check("rst_valid", 32'(pc_valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check_flags("rst", 1'b0, 1'b0);

        // BOOT lasts one cycle and ignores the step request.
        reset = 0; inc_en = 1;
        step();
        check("boot_pc", 32'(pc), 32'h10);
        check("boot_valid", 32'(pc_valid), 32'd1);
        step(); check("inc1", 32'(pc), 32'h11);
        step(); check("inc2", 32'(pc), 32'h12);
        step(); check("inc3", 32'(pc), 32'h13);

        // Wrap-around and negative branch.
        idle(); jmp_en = 1; jmp_addr = 8'hFF;
        step(); check("jmp_ff", 32'(pc), 32'hFF);
        idle(); inc_en = 1;
        step(); check("wrap", 32'(pc), 32'h00);
        check_flags("wrap", 1'b0, 1'b0);
        idle(); jmp_en = 1; jmp_addr = 8'h05;
        step();
        idle(); br_en = 1; br_offset = 8'hFE;
        step(); check("br_neg", 32'(pc), 32'h03);

        // Priority, then stalled request dropped rather than queued.
        idle(); jmp_en = 1; br_en = 1; inc_en = 1; jmp_addr = 8'h40; br_offset = 8'h07;
        step(); check("prio_jmp", 32'(pc), 32'h40);
        stall = 1; jmp_addr = 8'h60;
        step(); check("stall_hold", 32'(pc), 32'h40);
        idle();
        step(); check("stall_drop", 32'(pc), 32'h40);
        br_en = 1; inc_en = 1; br_offset = 8'h03;
        step(); check("prio_br", 32'(pc), 32'h43);

        // Halt/resume.
        idle(); jmp_en = 1; jmp_addr = 8'h22;
        step(); check("pre_halt", 32'(pc), 32'h22);
        idle(); halt = 1; inc_en = 1;
        step();
        check("halt_entry_pc", 32'(pc), 32'h22);
        check("halt_entry_h", 32'(halted), 32'd1);
        halt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("halt_pc%0d", i), 32'(pc), 32'h22);
            check($sformatf("halt_h%0d", i), 32'(halted), 32'd1);
            check($sformatf("halt_v%0d", i), 32'(pc_valid), 32'd0);
        end
        halt = 1; resume = 1;
        step();
        check("resume_pc", 32'(pc), 32'h22);
        check("resume_h", 32'(halted), 32'd0);
        check("resume_v", 32'(pc_valid), 32'd1);
        idle(); inc_en = 1;
        step(); check("post_resume", 32'(pc), 32'h23);
        idle(); stall = 1; halt = 1;
        step(); check("stall_blocks_halt", 32'(halted), 32'd0);
        idle();

`ifdef PC_RAS_EN
        jmp_en = 1; jmp_addr = 8'h10;
        step();
        idle(); call_en = 1; jmp_addr = 8'h80;
        step(); check("call", 32'(pc), 32'h80);
        idle(); ret_en = 1;
        step(); check("ret", 32'(pc), 32'h11);
        idle(); call_en = 1;
        for (int i = 0; i < 5; i++) begin
            jmp_addr = 8'(8'h20 + 8'(i) * 8'h10);
            step();
            check($sformatf("ncall_pc%0d", i), 32'(pc), 32'(8'h20 + 8'(i) * 8'h10));
            check($sformatf("ncall_ovf%0d", i), 32'(ras_overflow), 32'(i == 4));
        end
        idle(); ret_en = 1;
        step(); check("nret0", 32'(pc), 32'h41);
        step(); check("nret1", 32'(pc), 32'h31);
        step(); check("nret2", 32'(pc), 32'h21);
        step(); check("nret3", 32'(pc), 32'h12);
        check("nret3_unf", 32'(ras_underflow), 32'd0);
        step(); check("nret4", 32'(pc), 32'h13);
        check_flags("nret4", 1'b1, 1'b1);
`else
        call_en = 1; jmp_addr = 8'h80;
        step(); check("call_as_jmp", 32'(pc), 32'h80);
        idle(); ret_en = 1;
        step(); check("ret_ignored", 32'(pc), 32'h80);
        inc_en = 1;
        step(); check("ret_inc", 32'(pc), 32'h81);
        check_flags("noras", 1'b0, 1'b0);
`endif

        // Reset dominating a jump, then a stalled HALT.
        idle(); jmp_en = 1; jmp_addr = 8'h77; reset = 1;
        step();
        check("rst_jmp_pc", 32'(pc), 32'h10);
        check("rst_jmp_v", 32'(pc_valid), 32'd0);
        check_flags("rst_jmp", 1'b0, 1'b0);
        reset = 0; idle(); ret_en = 1;
        step(); check("rst_boot_pc", 32'(pc), 32'h10);
        step();
`ifdef PC_RAS_EN
        check("rst_sp_empty", 32'(pc), 32'h11);
        check("rst_sp_unf", 32'(ras_underflow), 32'd1);
`else
        check("rst_ret_ign", 32'(pc), 32'h10);
`endif
        idle(); halt = 1;
        step(); check("halt2", 32'(halted), 32'd1);
        idle(); reset = 1; stall = 1; inc_en = 1;
        step();
        check("rst_halt_h", 32'(halted), 32'd0);
        check("rst_halt_pc", 32'(pc), 32'h10);
        check("rst_halt_v", 32'(pc_valid), 32'd0);
        check_flags("rst_halt", 1'b0, 1'b0);
        reset = 0; stall = 0;
        step();
        check("reboot_pc", 32'(pc), 32'h10);
        check("reboot_v", 32'(pc_valid), 32'd1);
        step(); check("reboot_inc", 32'(pc), 32'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
